serial_add_ctrl: RTL and testbench

Bit-serial add/subtract unit for area-constrained builds of the ALU. It sequences a single 1-bit full-adder cell over WIDTH cycles, one operand bit per cycle, LSB first. The carry is kept in a register between bits. Operands are captured with a start/busy/done handshake, and the block reports the result, carry-out and signed overflow to the ALU result mux.

---
 rtl/serial_add_if.sv | 24 ++
 rtl/serial_add_ctrl.sv | 108 ++++++++++
 tb/tb_serial_add_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle between the ALU sequencer and the bit-serial adder.
interface serial_add_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell stepped over WIDTH cycles, LSB first,
// with a registered carry and a start/busy/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  serial_add_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             s, co;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    s       = a_q[0] ^ b_q[0] ^ c_q;
    co      = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {s, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          // c_q here is the carry into the MSB; co is the final carry.
          cout_d  = co;
          ovf_d   = c_q ^ co;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  serial_add_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus signed range check.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic co, output logic ov);
    longint sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = a - b;
      co = (a >= b);
      sr = sa - sb;
    end else begin
      r  = a + b;
      co = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
      sr = sa + sb;
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = s;
    @(negedge clk);
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    logic [W-1:0] er;
    logic ec, eo;
    int n, busy_cnt;
    model(a, b, s, er, ec, eo);
    launch(a, b, s);
    chk({tag, "_busy_on"}, bus.busy, 1);
    n = 0; busy_cnt = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    chk({tag, "_latency"}, n + 1, W + 1);
    if (n >= 100) return;
    chk({tag, "_busy_cycles"}, busy_cnt, W + 1);
    chk({tag, "_result"}, bus.result, er);
    chk({tag, "_cout"}, bus.carry_out, ec);
    chk({tag, "_ovf"}, bus.overflow, eo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
    chk({tag, "_hold"}, bus.result, er);
  endtask

  initial begin
    int dones, last, pulses;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow}, '0);
    rst = 1'b0;

    run_op("add_5_7", 32'd5, 32'd7, 1'b0);
    run_op("uwrap", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("sovf", 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op("sub_3_5", 32'd3, 32'd5, 1'b1);
    run_op("sub_min", 32'h8000_0000, 32'd1, 1'b1);
    run_op("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b1);

    // Start pulses while busy must be ignored.
    launch(32'd5, 32'd7, 1'b0);
    dones = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        chk("ign_result", bus.result, 32'd12);
      end
      bus.start = (n == 10 || n == 32);
      bus.a = 32'd100; bus.b = 32'd100;
    end
    bus.start = 1'b0;
    chk("ign_done_count", dones, 1);
    chk("ign_idle", bus.busy, 0);

    // Reset mid-operation discards the op with no done pulse.
    launch(32'h7FFF_FFFF, 32'd1, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", {bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow}, '0);
    dones = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op("after_rst", 32'd2, 32'd2, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.sub = 1'b0;
    last = -1; pulses = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (last >= 0 && n == last + 1) chk("b2b_hold", bus.result, 32'd2);
      if (bus.done === 1'b1) begin
        chk("b2b_result", bus.result, 32'd2);
        if (last >= 0) chk("b2b_spacing", n - last, W + 2);
        last = n;
        pulses++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_pulses", pulses, 4);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = {$urandom_range(1, 0), {(W-1){ra[0]}}};
      run_op("rand", ra, rb, 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
